// File: rtl/serial_uart_tx.sv
`timescale 1ns/1ps
// serial_uart_tx: stream-to-pin UART transmitter, 8N1-style frames.
// A one-word holding register lets the producer queue the next word during a
// frame, so consecutive frames go out back-to-back with no idle gap.
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   data, valid      producer word / word present (accepted when valid && ready)
//   ready            holding register empty (registered)
//   cts              clear-to-send, sampled only when a frame is about to start
//   tx               serial line, idle high
//   busy             frame in progress or a word is held
module serial_uart_tx #(
    parameter int BITS      = 8,
    parameter int DIVISOR   = 16,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [BITS-1:0] data,
    input  logic            valid,
    output logic            ready,
    input  logic            cts,
    output logic            tx,
    output logic            busy
);

    localparam int BW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int CMAX = (BITS > STOP_BITS) ? BITS : STOP_BITS;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(DIVISOR - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q;
    logic [BITS-1:0] hold_q;
    logic            hold_full_q;
    logic            hold_full_d;
    logic [BITS-1:0] shreg_q;
    logic [BW-1:0]   baud_q;
    logic [CW-1:0]   bit_q;
    logic            tx_q;
    logic            ready_q;

    logic accept;
    logic baud_last;
    logic start_ok;
    logic load;

    always_comb begin
        accept    = valid && ready_q;
        baud_last = (baud_q == BAUD_LAST);
        start_ok  = hold_full_q && cts;
        // A new frame starts from IDLE, or directly off the final stop cycle.
        load      = start_ok &&
                    ((state_q == S_IDLE) ||
                     ((state_q == S_STOP) && baud_last && (bit_q == STOP_LAST)));
        // A same-edge accept refills hold as the transfer empties it.
        hold_full_d = accept || (hold_full_q && !load);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            baud_q      <= '0;
            bit_q       <= '0;
            tx_q        <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            ready_q     <= !hold_full_d;
            if (accept) begin
                hold_q <= data;
            end
            if (load) begin
                shreg_q <= hold_q;
                state_q <= S_START;
                tx_q    <= 1'b0;
                baud_q  <= '0;
                bit_q   <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        tx_q   <= 1'b1;
                        baud_q <= '0;
                        bit_q  <= '0;
                    end
                    S_START: begin
                        if (baud_last) begin
                            state_q <= S_DATA;
                            baud_q  <= '0;
                            bit_q   <= '0;
                            tx_q    <= shreg_q[0];
                        end else begin
                            baud_q <= baud_q + BW'(1);
                        end
                    end
                    S_DATA: begin
                        if (baud_last) begin
                            baud_q <= '0;
                            if (bit_q == BIT_LAST) begin
                                state_q <= S_STOP;
                                bit_q   <= '0;
                                tx_q    <= 1'b1;
                            end else begin
                                // Present the next bit as the register shifts.
                                shreg_q <= shreg_q >> 1;
                                tx_q    <= shreg_q[1];
                                bit_q   <= bit_q + CW'(1);
                            end
                        end else begin
                            baud_q <= baud_q + BW'(1);
                        end
                    end
                    S_STOP: begin
                        if (baud_last) begin
                            baud_q <= '0;
                            if (bit_q == STOP_LAST) begin
                                state_q <= S_IDLE;
                                bit_q   <= '0;
                                tx_q    <= 1'b1;
                            end else begin
                                bit_q <= bit_q + CW'(1);
                            end
                        end else begin
                            baud_q <= baud_q + BW'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        tx_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign busy  = (state_q != S_IDLE) || hold_full_q;

endmodule

// File: tb/tb_serial_uart_tx.sv
`timescale 1ns/1ps
// tb_serial_uart_tx: table-driven frame checks, hand-written corner sequences
// and a random run against a line-level reference model.
module tb_serial_uart_tx;

    localparam int BITS = 8;
    localparam int DIV  = 4;
    localparam int FLEN = (1 + BITS + 1) * DIV;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       cts_man = 1'b1;
    logic       cts_rnd = 1'b1;
    logic       rand_en = 1'b0;
    logic       cts;
    logic       tx, ready, busy;

    logic [6:0] datab = 7'h00;
    logic       validb = 1'b0;
    logic       txb, readyb, busyb;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    assign cts = rand_en ? cts_rnd : cts_man;

    serial_uart_tx #(.BITS(8), .DIVISOR(4), .STOP_BITS(1)) dut (
        .clk(clk), .resetn(resetn), .data(data), .valid(valid),
        .ready(ready), .cts(cts), .tx(tx), .busy(busy)
    );

    serial_uart_tx #(.BITS(7), .DIVISOR(3), .STOP_BITS(2)) dutb (
        .clk(clk), .resetn(resetn), .data(datab), .valid(validb),
        .ready(readyb), .cts(1'b1), .tx(txb), .busy(busyb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Line model: a frame is a fixed-length sequence of bit periods; a new
    // frame begins at any edge where the line is free, a word is pending
    // and cts is high.
    int         mpos = -1;
    logic       mhf = 1'b0;
    logic       mready = 1'b0;
    logic [7:0] mhold = 8'h00;
    logic [7:0] mframe = 8'h00;

    always @(posedge clk) begin
        logic acc, free;
        if (!resetn) begin
            mpos   = -1;
            mhf    = 1'b0;
            mready = 1'b0;
        end else begin
            acc  = valid && mready;
            free = (mpos == -1) || (mpos == FLEN - 1);
            if (free && mhf && cts) begin
                mframe = mhold;
                mpos   = 0;
                mhf    = 1'b0;
            end else if (free) begin
                mpos = -1;
            end else begin
                mpos++;
            end
            if (acc) begin
                mhold = data;
                mhf   = 1'b1;
            end
            mready = !mhf;
        end
    end

    function automatic int exp_tx();
        int b;
        if (mpos < 0) return 1;
        b = mpos / DIV;
        if (b == 0) return 0;
        if (b <= BITS) return int'(mframe[b-1]);
        return 1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_tx", int'(tx), exp_tx());
            chk("model_ready", int'(ready), int'(mready));
            chk("model_busy", int'(busy), int'((mpos >= 0) || mhf));
        end
    end

    always @(negedge clk) begin
        if (rand_en) cts_rnd = ($urandom_range(0, 15) != 0);
    end

    typedef struct {
        logic [7:0] w;
        logic [9:0] line;
    } vec_t;

    vec_t tbl[6];
    int   last_wait;

    // Called at a negedge; returns at the negedge just after the accept edge.
    // data is scrambled while ready is low, which must have no effect.
    task automatic send(input logic [7:0] w);
        int n;
        n = 0;
        valid = 1'b1;
        while (!ready && n < 300) begin
            data = 8'($urandom);
            @(negedge clk);
            n++;
        end
        if (!ready) chk("send_timeout", 0, 1);
        data = w;
        @(negedge clk);
        valid = 1'b0;
        last_wait = n;
    endtask

    task automatic xmit_check(input vec_t v);
        logic [9:0] line;
        line = v.line;
        send(v.w);
        chk("idle_after_accept", int'(tx), 1);
        @(negedge clk);
        for (int i = 0; i < FLEN; i++) begin
            chk($sformatf("frame_%02h_c%0d", v.w, i), int'(tx), int'(line[i/DIV]));
            @(negedge clk);
        end
        chk("busy_after_frame", int'(busy), 0);
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", int'(busy), 0);
    endtask

    initial begin
        int cnt;
        logic [9:0] lb;

        tbl[0] = '{8'hA5, 10'h34A};
        tbl[1] = '{8'h00, 10'h200};
        tbl[2] = '{8'hFF, 10'h3FE};
        tbl[3] = '{8'h3C, 10'h278};
        tbl[4] = '{8'h5A, 10'h2B4};
        tbl[5] = '{8'h81, 10'h302};

        resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_tx", int'(tx), 1);
        chk("reset_ready", int'(ready), 0);
        chk("reset_busy", int'(busy), 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("ready_after_release", int'(ready), 1);

        for (int i = 0; i < 6; i++) xmit_check(tbl[i]);

        // Back-to-back 0x00 then 0xFF.
        send(8'h00);
        send(8'hFF);
        chk("b2b_ready_wait", last_wait, 1);
        chk("b2b_start_bit", int'(tx), 0);
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk("b2b_busy_run", cnt, 79);

        // cts low while a word waits.
        cts_man = 1'b0;
        send(8'h3C);
        repeat (10) begin
            chk("cts_wait_tx", int'(tx), 1);
            chk("cts_wait_ready", int'(ready), 0);
            chk("cts_wait_busy", int'(busy), 1);
            @(negedge clk);
        end
        cts_man = 1'b1;
        @(negedge clk);
        chk("cts_start", int'(tx), 0);
        repeat (FLEN) @(negedge clk);
        chk("cts_frame_done", int'(busy), 0);

        // cts drops mid-frame: frame finishes, queued word waits.
        send(8'hC3);
        send(8'h96);
        repeat (8) @(negedge clk);
        cts_man = 1'b0;
        repeat (50) @(negedge clk);
        chk("ctsdrop_tx", int'(tx), 1);
        chk("ctsdrop_busy", int'(busy), 1);
        chk("ctsdrop_ready", int'(ready), 0);
        cts_man = 1'b1;
        repeat (45) @(negedge clk);
        chk("ctsdrop_done", int'(busy), 0);

        // Reset during data bit 3.
        send(8'hF7);
        repeat (17) @(negedge clk);
        chk("pre_reset_bit3", int'(tx), 0);
        resetn = 1'b0;
        @(negedge clk);
        chk("midreset_tx", int'(tx), 1);
        chk("midreset_ready", int'(ready), 0);
        chk("midreset_busy", int'(busy), 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("midreset_release_ready", int'(ready), 1);
        xmit_check(tbl[5]);

        // 7 data bits, 2 stop bits, divisor 3.
        lb = 10'h3AA;
        datab = 7'h55;
        validb = 1'b1;
        chk("b_ready", int'(readyb), 1);
        @(negedge clk);
        validb = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            chk($sformatf("b_frame_c%0d", i), int'(txb), int'(lb[i/3]));
            @(negedge clk);
        end
        chk("b_busy_after", int'(busyb), 0);

        // Random run against the model.
        rand_en = 1'b1;
        for (int k = 0; k < 150; k++) begin
            send(8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rand_en = 1'b0;
        wait_idle(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
